// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single memory port: round-robin grant between
// core and loader, read-latency sequencing, write completion/timeout, error pulses.
module mem_port_arbiter #(
  parameter int READ_LAT   = 2,
  parameter int WR_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic [31:0] c_addr,
  input  logic [1:0]  c_wmode,
  input  logic [31:0] c_wdata,
  output logic        c_ack,
  output logic        c_err,
  input  logic        l_req,
  input  logic [31:0] l_addr,
  input  logic [1:0]  l_wmode,
  input  logic [31:0] l_wdata,
  output logic        l_ack,
  output logic        l_err,
  output logic [31:0] rdata,
  output logic [31:0] m_addr,
  output logic [1:0]  m_wmode,
  output logic [7:0]  m_wbyte,
  output logic [15:0] m_whalf,
  output logic [31:0] m_wword,
  input  logic [31:0] m_word,
  input  logic        m_done,
  input  logic        m_error
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [7:0] RD_LOAD = 8'(READ_LAT - 1);
  localparam logic [7:0] TO_LAST = 8'(WR_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;      // read latency down-counter / write wait up-counter
  logic        gnt_l;    // 1 = loader owns the current transaction
  logic        last_l;   // 1 = loader was granted last
  logic        err_q;

  logic        pick_l;
  logic [31:0] sel_addr;
  logic [1:0]  sel_wmode;
  logic [31:0] sel_wdata;

  // Loader wins only if it alone requests, or on a tie when core went last.
  always_comb begin
    pick_l    = l_req && (!c_req || !last_l);
    sel_addr  = pick_l ? l_addr  : c_addr;
    sel_wmode = pick_l ? l_wmode : c_wmode;
    sel_wdata = pick_l ? l_wdata : c_wdata;
  end

  // NOTE: state and outputs are registers, so every assignment here is
  // non-blocking; blocking ones would make results depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt_l   <= 1'b0;
      last_l  <= 1'b1;
      err_q   <= 1'b0;
      c_ack   <= 1'b0;
      c_err   <= 1'b0;
      l_ack   <= 1'b0;
      l_err   <= 1'b0;
      rdata   <= '0;
      m_addr  <= '0;
      m_wmode <= '0;
      m_wbyte <= '0;
      m_whalf <= '0;
      m_wword <= '0;
    end else begin
      // Acks default low so they can only ever be one-cycle pulses.
      c_ack <= 1'b0;
      c_err <= 1'b0;
      l_ack <= 1'b0;
      l_err <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req || l_req) begin
            gnt_l   <= pick_l;
            err_q   <= 1'b0;
            m_addr  <= sel_addr;
            m_wbyte <= sel_wdata[7:0];
            m_whalf <= sel_wdata[15:0];
            m_wword <= sel_wdata;
            if (sel_wmode == 2'd0) begin
              cnt   <= RD_LOAD;
              state <= READ;
            end else begin
              cnt     <= '0;
              m_wmode <= sel_wmode;
              state   <= WRITE;
            end
          end
        end
        READ: begin
          if (cnt == 8'd0) begin
            rdata <= m_word;
            err_q <= m_error;
            state <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WRITE: begin
          // cnt == 0 marks the first write cycle, the only one m_error is honoured in.
          if (cnt == 8'd0 && m_error) begin
            m_wmode <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else if (m_done) begin
            m_wmode <= '0;
            state   <= RESP;
          end else if (cnt == TO_LAST) begin
            m_wmode <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          c_ack  <= !gnt_l;
          l_ack  <= gnt_l;
          c_err  <= !gnt_l && err_q;
          l_err  <= gnt_l && err_q;
          last_l <= gnt_l;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written round-robin, write-timeout and mid-write reset sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, l_req;
  logic [31:0] c_addr, l_addr, c_wdata, l_wdata;
  logic [1:0]  c_wmode, l_wmode;
  logic        c_ack, c_err, l_ack, l_err;
  logic [31:0] rdata, m_addr, m_wword, m_word;
  logic [1:0]  m_wmode;
  logic [7:0]  m_wbyte;
  logic [15:0] m_whalf;
  logic        m_done, m_error;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.READ_LAT(2), .WR_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_wmode(c_wmode), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_err(c_err),
    .l_req(l_req), .l_addr(l_addr), .l_wmode(l_wmode), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_err(l_err),
    .rdata(rdata), .m_addr(m_addr), .m_wmode(m_wmode),
    .m_wbyte(m_wbyte), .m_whalf(m_whalf), .m_wword(m_wword),
    .m_word(m_word), .m_done(m_done), .m_error(m_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ldr;
    logic [31:0] addr;
    logic [1:0]  wmode;
    logic [31:0] wdata;
    logic [31:0] mword;
    bit          merr;
    int          done_at;    // cycle (after grant) in which m_done is raised
    int          lat;        // expected ack cycle, counted from the request cycle
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ack(input int limit, output bit who_l, output int cycles, output bit err);
    bit seen = 0;
    who_l = 0; cycles = 0; err = 0;
    for (int k = 1; k <= limit && !seen; k++) begin
      @(negedge clk);
      if (c_ack || l_ack) begin
        seen = 1; who_l = l_ack; cycles = k; err = c_err | l_err;
        check("single_ack", {30'd0, c_ack, l_ack} == 32'd3, 1'b0);
      end
    end
    check("ack_seen", seen, 1'b1);
  endtask

  task automatic run_txn(input vec_t v);
    bit          done = 0;
    logic [1:0]  exp_m;
    if (v.ldr) begin
      l_req = 1; l_addr = v.addr; l_wmode = v.wmode; l_wdata = v.wdata;
    end else begin
      c_req = 1; c_addr = v.addr; c_wmode = v.wmode; c_wdata = v.wdata;
    end
    m_word = v.mword; m_error = v.merr; m_done = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("m_addr", m_addr, v.addr);
        if (v.wmode != 2'd0) begin
          check("m_wword", m_wword, v.wdata);
          check("m_whalf", {16'd0, m_whalf}, {16'd0, v.wdata[15:0]});
          check("m_wbyte", {24'd0, m_wbyte}, {24'd0, v.wdata[7:0]});
        end
        // Granted inputs must not be re-sampled once the transaction is running.
        if (v.ldr) begin l_addr = ~v.addr; l_wdata = ~v.wdata; l_wmode = ~v.wmode; end
        else       begin c_addr = ~v.addr; c_wdata = ~v.wdata; c_wmode = ~v.wmode; end
      end
      exp_m = (v.wmode != 2'd0 && k <= v.lat - 2) ? v.wmode : 2'd0;
      check("m_wmode", {30'd0, m_wmode}, {30'd0, exp_m});
      check("m_addr_held", m_addr, v.addr);
      m_done = (v.wmode != 2'd0) && (k >= v.done_at);
      if (c_ack || l_ack) begin
        done = 1;
        check("latency", k, v.lat);
        check("c_ack", c_ack, !v.ldr);
        check("l_ack", l_ack, v.ldr);
        check("c_err", c_err, !v.ldr && v.exp_err);
        check("l_err", l_err, v.ldr && v.exp_err);
        check("rdata", rdata, v.exp_rdata);
        c_req = 0; l_req = 0; m_done = 0; m_error = 0;
      end
    end
    check("ack_seen", done, 1'b1);
    @(negedge clk);
    check("ack_pulse", {30'd0, c_ack, l_ack}, 32'd0);
  endtask

  initial begin
    bit who_l, err;
    int cyc, wcnt;
    bit stray;

    vecs[0] = '{0, 32'h10,  2'd0, 32'h0,        32'hDEADBEEF, 0, 99, 4, 0, 32'hDEADBEEF};
    vecs[1] = '{1, 32'h44,  2'd0, 32'h0,        32'h0BADF00D, 1, 99, 4, 1, 32'h0BADF00D};
    vecs[2] = '{1, 32'h20,  2'd3, 32'h12345678, 32'h0,        0, 5,  7, 0, 32'h0BADF00D};
    vecs[3] = '{0, 32'h21,  2'd2, 32'hFFFFABCD, 32'h0,        1, 99, 3, 1, 32'h0BADF00D};
    vecs[4] = '{0, 32'h33,  2'd1, 32'h0000005A, 32'h0,        0, 1,  3, 0, 32'h0BADF00D};
    vecs[5] = '{1, 32'h100, 2'd0, 32'h0,        32'h13572468, 0, 99, 4, 0, 32'h13572468};

    rst = 0; c_req = 0; l_req = 0; c_addr = 0; l_addr = 0; c_wmode = 0; l_wmode = 0;
    c_wdata = 0; l_wdata = 0; m_word = 0; m_done = 0; m_error = 0;
    repeat (3) @(negedge clk);
    check("rst_acks", {28'd0, c_ack, c_err, l_ack, l_err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wmode", {30'd0, m_wmode}, 32'd0);
    check("rst_m_wdata", m_wword | {16'd0, m_whalf} | {24'd0, m_wbyte}, 32'd0);
    rst = 1;
    @(negedge clk);

    // Tie after reset: core first; core re-requests at once, so loader wins next.
    c_req = 1; l_req = 1; c_addr = 32'h8; l_addr = 32'hC; m_word = 32'h11112222;
    wait_ack(20, who_l, cyc, err);
    check("rr1_who", who_l, 1'b0);
    check("rr1_lat", cyc, 4);
    wait_ack(20, who_l, cyc, err);
    check("rr2_who", who_l, 1'b1);
    check("rr2_lat", cyc, 4);
    l_req = 0;
    wait_ack(20, who_l, cyc, err);
    check("rr3_who", who_l, 1'b0);
    check("rr3_err", err, 1'b0);
    c_req = 0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Write with m_done stuck low: 255 cycles of m_wmode, then ack with error.
    c_req = 1; c_addr = 32'h40; c_wmode = 2'd3; c_wdata = 32'hCAFEF00D; m_done = 0;
    wcnt = 0; cyc = 0; err = 0;
    for (int k = 1; k <= 300 && cyc == 0; k++) begin
      @(negedge clk);
      if (m_wmode != 2'd0) wcnt++;
      if (c_ack) begin cyc = k; err = c_err; c_req = 0; end
    end
    check("to_wmode_cycles", wcnt, 255);
    check("to_latency", cyc, 257);
    check("to_err", err, 1'b1);
    @(negedge clk);
    run_txn('{0, 32'h50, 2'd0, 32'h0, 32'h600DCAFE, 0, 99, 4, 0, 32'h600DCAFE});

    // Reset in the middle of a loader write.
    l_req = 1; l_addr = 32'h60; l_wmode = 2'd3; l_wdata = 32'hA5A5A5A5; m_done = 0;
    repeat (3) @(negedge clk);
    check("pre_rst_wmode", {30'd0, m_wmode}, 32'd3);
    rst = 0;
    #1;
    check("mid_rst_wmode", {30'd0, m_wmode}, 32'd0);
    check("mid_rst_acks", {28'd0, c_ack, c_err, l_ack, l_err}, 32'd0);
    check("mid_rst_m_addr", m_addr, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    check("mid_rst_wword", m_wword, 32'd0);
    @(negedge clk);
    rst = 1; l_req = 0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (c_ack || l_ack || m_wmode != 2'd0) stray = 1;
    end
    check("post_rst_quiet", stray, 1'b0);
    run_txn('{1, 32'h70, 2'd0, 32'h0, 32'h89ABCDEF, 0, 99, 4, 0, 32'h89ABCDEF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
